// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: NREGS x DATA_W 2-read/1-write register file with a clear sequencer after reset.
// Define REG_FILE_BYPASS_EN to forward wd into a read port addressing the register written in the same edge.
module reg_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rdy
);
    localparam int NREGS = 2**ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, rdata1, rdata2;
    logic              last, clearing, rd_en;

    assign last     = cnt_q == ADDR_W'(NREGS - 1);
    assign clearing = state_q == CLEAR;
    assign rd_en    = !clearing && re;

`ifdef REG_FILE_BYPASS_EN
    assign rdata1 = (we && wn == rn1) ? wd : mem_q[rn1];
    assign rdata2 = (we && wn == rn2) ? wd : mem_q[rn2];
`else
    assign rdata1 = mem_q[rn1];
    assign rdata2 = mem_q[rn2];
`endif

    // The counter parks on the last register once READY so it never wraps.
    always_comb begin
        state_d = rst ? CLEAR : (clearing && last) ? READY : state_q;
        cnt_d   = rst ? '0 : (clearing && !last) ? cnt_q + 1'b1 : cnt_q;
        rd1_d   = rst ? '0 : rd_en ? rdata1 : rd1_q;
        rd2_d   = rst ? '0 : rd_en ? rdata2 : rd2_q;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rd1_q   <= rd1_d;
        rd2_q   <= rd2_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) mem_q[cnt_q] <= '0;
            else if (we) mem_q[wn] <= wd;
        end
    end

    assign rd1 = rd1_q;
    assign rd2 = rd2_q;
    assign rdy = state_q == READY;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed self-checking bench for reg_file_2r1w (default and REG_FILE_BYPASS_EN builds).
module tb_reg_file_2r1w;
    logic        clk = 1'b0;
    logic        rst, re, we;
    logic [3:0]  rn1, rn2, wn;
    logic [15:0] wd, rd1, rd2;
    logic        rdy;
    int          tests = 0;
    int          fails = 0;

    reg_file_2r1w dut (
        .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .re(re), .we(we),
        .wn(wn), .wd(wd), .rd1(rd1), .rd2(rd2), .rdy(rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b1; we = 1'b1; wn = 4'd5; wd = 16'hBEEF; rn1 = 4'd5; rn2 = 4'd0;
        tick();
        tick();
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        tests++; if (rd1 !== 16'h0) begin fails++; $display("FAIL reset_rd1 got=%h exp=0000", rd1); end
        tests++; if (rd2 !== 16'h0) begin fails++; $display("FAIL reset_rd2 got=%h exp=0000", rd2); end
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tests++; if (rdy !== (i == 16)) begin fails++; $display("FAIL clear_rdy edge=%0d got=%b exp=%b", i, rdy, i == 16); end
            tests++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin fails++; $display("FAIL clear_rd edge=%0d got=%h/%h exp=0000/0000", i, rd1, rd2); end
        end
        re = 1'b0; we = 1'b0;
    endtask

    task automatic test_write_read();
        we = 1'b1; wn = 4'd10; wd = 16'h00AA;
        tick();
        wn = 4'd13; wd = 16'h0DDD;
        tick();
        tests++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin fails++; $display("FAIL write_no_read got=%h/%h exp=0000/0000", rd1, rd2); end
        we = 1'b0; re = 1'b1; rn1 = 4'd10; rn2 = 4'd13;
        tick();
        tests++; if (rd1 !== 16'h00AA) begin fails++; $display("FAIL read_rd1 got=%h exp=00aa", rd1); end
        tests++; if (rd2 !== 16'h0DDD) begin fails++; $display("FAIL read_rd2 got=%h exp=0ddd", rd2); end
        re = 1'b0;
    endtask

    task automatic test_collision();
        logic [15:0] exp2;
`ifdef REG_FILE_BYPASS_EN
        exp2 = 16'h1234;
`else
        exp2 = 16'h00AA;
`endif
        we = 1'b1; wn = 4'd10; wd = 16'h1234; re = 1'b1; rn1 = 4'd13; rn2 = 4'd10;
        tick();
        tests++; if (rd1 !== 16'h0DDD) begin fails++; $display("FAIL coll_rd1 got=%h exp=0ddd", rd1); end
        tests++; if (rd2 !== exp2) begin fails++; $display("FAIL coll_rd2 got=%h exp=%h", rd2, exp2); end
        we = 1'b0; rn1 = 4'd10; rn2 = 4'd10;
        tick();
        tests++; if (rd1 !== 16'h1234 || rd2 !== 16'h1234) begin fails++; $display("FAIL coll_later got=%h/%h exp=1234/1234", rd1, rd2); end
        re = 1'b0;
    endtask

    task automatic test_same_addr_hold();
        re = 1'b1; rn1 = 4'd13; rn2 = 4'd13; we = 1'b0; wn = 4'd13; wd = 16'hFFFF;
        tick();
        tests++; if (rd1 !== 16'h0DDD || rd2 !== 16'h0DDD) begin fails++; $display("FAIL same_addr got=%h/%h exp=0ddd/0ddd", rd1, rd2); end
        re = 1'b0; rn1 = 4'd10; rn2 = 4'd5;
        tick();
        tick();
        tests++; if (rd1 !== 16'h0DDD || rd2 !== 16'h0DDD) begin fails++; $display("FAIL hold got=%h/%h exp=0ddd/0ddd", rd1, rd2); end
        re = 1'b1; rn1 = 4'd13; rn2 = 4'd13;
        tick();
        tests++; if (rd1 !== 16'h0DDD) begin fails++; $display("FAIL we0_nochange got=%h exp=0ddd", rd1); end
        re = 1'b0;
    endtask

    task automatic test_clear_write_ignored();
        re = 1'b1; rn1 = 4'd5; rn2 = 4'd5;
        tick();
        tests++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin fails++; $display("FAIL clear_we_ignored got=%h/%h exp=0000/0000", rd1, rd2); end
        re = 1'b0;
    endtask

    task automatic test_reset_ready();
        re = 1'b1; rn1 = 4'd13; rn2 = 4'd10;
        tick();
        re = 1'b0;
        rst = 1'b1; we = 1'b1; wn = 4'd3; wd = 16'h7777;
        tick();
        tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL rerst_rdy got=%b exp=0", rdy); end
        tests++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin fails++; $display("FAIL rerst_rd got=%h/%h exp=0000/0000", rd1, rd2); end
        rst = 1'b0; we = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            tests++; if (rdy !== (i == 16)) begin fails++; $display("FAIL reclear_rdy edge=%0d got=%b exp=%b", i, rdy, i == 16); end
        end
        re = 1'b1; rn1 = 4'd10; rn2 = 4'd13;
        tick();
        tests++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin fails++; $display("FAIL recleared got=%h/%h exp=0000/0000", rd1, rd2); end
        rn1 = 4'd3; rn2 = 4'd3;
        tick();
        tests++; if (rd1 !== 16'h0) begin fails++; $display("FAIL rst_write_discard got=%h exp=0000", rd1); end
        re = 1'b0;
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; rn1 = '0; rn2 = '0; wn = '0; wd = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_same_addr_hold();
        test_clear_write_ignored();
        test_reset_ready();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter: DATA_W, 16, register width in bits.
REQ-002 Parameter: ADDR_W, 4, register-number width; NREGS = 2**ADDR_W (16).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: rn1  input  ADDR_W  read-port-1 register number.
REQ-006 Port: rn2  input  ADDR_W  read-port-2 register number (driven by upstream B-operand register-select mux).
REQ-007 Port: re  input  1  read enable; captures both read ports.
REQ-008 Port: we  input  1  write enable.
REQ-009 Port: wn  input  ADDR_W  write register number.
REQ-010 Port: wd  input  DATA_W  write data.
REQ-011 Port: rd1  output  DATA_W  registered read data, port 1.
REQ-012 Port: rd2  output  DATA_W  registered read data, port 2.
REQ-013 Port: rdy  output  1  high when the clear sequence is done and the file accepts accesses.
REQ-014 One clock; reset is synchronous and active-high; ports named clk and rst.

Function
REQ-015 Storage SHALL be NREGS x DATA_W flops; no reset-value array, contents initialised only by the clear sequencer.
REQ-016 Two-state FSM SHALL be used: CLEAR and READY.
REQ-017 CLEAR: each edge writes 0 to reg[clr_cnt] and increments clr_cnt; on clr_cnt == NREGS-1, next state is READY.
REQ-018 rdy SHALL be a registered output, 0 in CLEAR, 1 in READY; rdy rises on the 16th rising edge after the edge at which rst is first sampled low.
REQ-019 In CLEAR, we and re SHALL be ignored; rd1/rd2 hold 0.
REQ-020 READY, we=1: reg[wn] <= wd at the edge; we=0: no storage change.
REQ-021 READY, re=1: rd1 <= reg[rn1], rd2 <= reg[rn2] at the edge (one-cycle latency); re=0: rd1/rd2 hold.
REQ-022 rn1 == rn2 SHALL return identical data on both ports.
REQ-023 Simultaneous we=1, re=1 with wn equal to rn1 and/or rn2: behaviour per REQ-028/REQ-029; the storage write always occurs.
REQ-024 clr_cnt SHALL not wrap or restart while in READY; READY is exited only by rst.

Reset
REQ-025 rst=1 at an edge SHALL set state=CLEAR, clr_cnt=0, rdy=0, rd1=0, rd2=0.
REQ-026 rst asserted mid-clear or in READY SHALL restart the clear from register 0; a write in the reset cycle is discarded.
REQ-027 Held rst keeps all outputs at 0; the clear begins on the first edge with rst=0.

Configuration
REQ-028 Macro REG_FILE_BYPASS_EN defined: on a same-address write/read collision, the colliding read port captures wd (new data) in that edge.
REQ-029 Macro undefined: the colliding read port captures the pre-write stored value; new data is visible on the next read.

Verification
REQ-030 Assert rst 2 cycles, release -> rdy=0 for 15 edges, rdy=1 at edge 16; rd1=rd2=0 throughout.
REQ-031 After rdy: write wn=10 wd=0x00AA, wn=13 wd=0x0DDD; then re=1 rn1=10 rn2=13 -> next edge rd1=0x00AA, rd2=0x0DDD.
REQ-032 Same edge we=1 wn=10 wd=0x1234, re=1 rn2=10, reg[10]=0x00AA -> rd2=0x1234 with REG_FILE_BYPASS_EN, 0x00AA without; a later read returns 0x1234 in both builds.
REQ-033 rn1=rn2=13, re=1 -> rd1=rd2=0x0DDD; then re=0 with rn1/rn2 changed -> outputs hold 0x0DDD.
REQ-034 rst pulsed 1 cycle in READY after writes -> rdy=0, rd=0, 16-cycle clear reruns; reading regs 10, 13 afterwards -> 0x0000.
REQ-035 we=1 wn=5 wd=0xBEEF during CLEAR -> after rdy, reading reg 5 -> 0x0000.
